mem64_arbiter: RTL and testbench

- Two-port arbiter that shares the single 64-bit data memory (Memoria64) between requester 0 (CPU load/store path under UniControle) and requester 1 (debug/loader port).
- Latches one request at a time, drives the memory address/data/write strobe, and times the read return to the requester that owns the access.
- Sits between the requesters and the memory instance in the top-level CPU.

---
 rtl/mem64_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem64_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem64_arbiter.sv
// Two-port round-robin arbiter in front of the shared 64-bit data memory.
// Define MEM64_ARB_FIXED_PRIO_EN to make port 0 always win a tie.
module mem64_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int RD_LAT = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              req0,
   input  logic              wr0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam logic [2:0] LAT_C = 3'(RD_LAT);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              lat_wr_q, lat_wr_d;
   logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_wr_q, mem_wr_d;
   logic              win_s;

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner_q;
      lat_wr_d    = lat_wr_q;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wr_d    = 1'b0;
      win_s       = 1'b0;

`ifdef MEM64_ARB_FIXED_PRIO_EN
      win_s = ~req0;
`else
      if (req0 && req1) begin
         win_s = ~owner_q;
      end else begin
         win_s = req1;
      end
`endif

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               state_d  = S_ACCESS;
               owner_d  = win_s;
               mem_wr_d = win_s ? wr1 : wr0;
               lat_wr_d = win_s ? wr1 : wr0;
               mem_addr_d  = win_s ? addr1 : addr0;
               mem_wdata_d = win_s ? wdata1 : wdata0;
               gnt0_d   = ~win_s;
               gnt1_d   = win_s;
            end else begin
               mem_addr_d = '0;
            end
         end
         S_ACCESS: begin
            if (lat_wr_q) begin
               state_d    = S_IDLE;
               mem_addr_d = '0;
            end else begin
               state_d = S_WAIT;
               cnt_d   = LAT_C;
            end
         end
         // Last WAIT cycle carries valid memory data; capture it for the owner only
         S_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = S_RESP;
               cnt_d   = 3'd0;
               if (owner_q) begin
                  rdata1_d  = mem_rdata;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = mem_rdata;
                  rvalid0_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_RESP: begin
            state_d    = S_IDLE;
            mem_addr_d = '0;
         end
         default: begin
            state_d    = S_IDLE;
            mem_addr_d = '0;
         end
      endcase
   end

   // State and output registers; owner resets to 1 so port 0 wins the first tie
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         owner_q     <= 1'b1;
         lat_wr_q    <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         owner_q     <= owner_d;
         lat_wr_q    <= lat_wr_d;
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wr_q    <= mem_wr_d;
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wr    = mem_wr_q;
   assign busy      = (state_q != S_IDLE);
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem64_arbiter.sv
// Directed bench for mem64_arbiter: instance a uses RD_LAT=1, instance b uses RD_LAT=4,
// each backed by a small latency-accurate memory model.
module tb_mem64_arbiter;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   logic        req0_a = 1'b0, wr0_a = 1'b0, req1_a = 1'b0, wr1_a = 1'b0;
   logic [63:0] addr0_a = 64'd0, wdata0_a = 64'd0, addr1_a = 64'd0, wdata1_a = 64'd0;
   logic        gnt0_a, rvalid0_a, gnt1_a, rvalid1_a, mem_wr_a, busy_a, owner_a;
   logic [63:0] rdata0_a, rdata1_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

   logic        req0_b = 1'b0, wr0_b = 1'b0, req1_b = 1'b0, wr1_b = 1'b0;
   logic [63:0] addr0_b = 64'd0, wdata0_b = 64'd0, addr1_b = 64'd0, wdata1_b = 64'd0;
   logic        gnt0_b, rvalid0_b, gnt1_b, rvalid1_b, mem_wr_b, busy_b, owner_b;
   logic [63:0] rdata0_b, rdata1_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

   mem64_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(1)) u_dut_a (
      .Clk(Clk), .Reset(Reset),
      .req0(req0_a), .wr0(wr0_a), .addr0(addr0_a), .wdata0(wdata0_a),
      .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
      .req1(req1_a), .wr1(wr1_a), .addr1(addr1_a), .wdata1(wdata1_a),
      .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
      .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a),
      .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a));

   mem64_arbiter #(.ADDR_W(64), .DATA_W(64), .RD_LAT(4)) u_dut_b (
      .Clk(Clk), .Reset(Reset),
      .req0(req0_b), .wr0(wr0_b), .addr0(addr0_b), .wdata0(wdata0_b),
      .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
      .req1(req1_b), .wr1(wr1_b), .addr1(addr1_b), .wdata1(wdata1_b),
      .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
      .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b));

   // Memory models: read data appears RD_LAT cycles after the address
   logic [63:0] mem_a [0:255];
   logic [63:0] mem_b [0:255];
   logic [63:0] rd_a = 64'd0;
   logic [63:0] pipe_b [0:3];

   always @(posedge Clk) begin
      rd_a <= mem_a[mem_addr_a[7:0]];
      if (mem_wr_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
   end
   assign mem_rdata_a = rd_a;

   always @(posedge Clk) begin
      pipe_b[0] <= mem_b[mem_addr_b[7:0]];
      for (int k = 1; k < 4; k++) pipe_b[k] <= pipe_b[k-1];
      if (mem_wr_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
   end
   assign mem_rdata_b = pipe_b[3];

   int n_checks = 0;
   int n_fail = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   int ngr, overlap, wr_cnt, lat, seen, nrv;
   logic [63:0] exp_port, last_rd;

   initial begin
      // Reset state
      tick();
      check_val("rst_busy", {63'd0, busy_a}, 64'd0);
      check_val("rst_owner", {63'd0, owner_a}, 64'd1);
      check_val("rst_gnt", {62'd0, gnt0_a, gnt1_a}, 64'd0);
      check_val("rst_maddr", mem_addr_a, 64'd0);
      Reset = 1'b0;

      // 1: port 0 write
      req0_a = 1'b1; wr0_a = 1'b1; addr0_a = 64'h10; wdata0_a = 64'hDEADBEEF;
      tick();
      check_val("t1_gnt0", {63'd0, gnt0_a}, 64'd1);
      check_val("t1_memwr", {63'd0, mem_wr_a}, 64'd1);
      check_val("t1_maddr", mem_addr_a, 64'h10);
      check_val("t1_mwdata", mem_wdata_a, 64'hDEADBEEF);
      req0_a = 1'b0;
      tick();
      check_val("t1_busy", {63'd0, busy_a}, 64'd0);
      check_val("t1_memwr_off", {63'd0, mem_wr_a}, 64'd0);
      check_val("t1_maddr_idle", mem_addr_a, 64'd0);

      // 2: port 1 read, RD_LAT=1
      req1_a = 1'b1; wr1_a = 1'b0; addr1_a = 64'h10;
      tick();
      check_val("t2_gnt1", {63'd0, gnt1_a}, 64'd1);
      req1_a = 1'b0;
      tick();
      check_val("t2_rv_early", {63'd0, rvalid1_a}, 64'd0);
      tick();
      check_val("t2_rvalid1", {63'd0, rvalid1_a}, 64'd1);
      check_val("t2_rdata1", rdata1_a, 64'hDEADBEEF);
      check_val("t2_rdata0", rdata0_a, 64'd0);
      tick();
      check_val("t2_busy", {63'd0, busy_a}, 64'd0);

      // 4: RD_LAT=4 timing on instance b
      req0_b = 1'b1; wr0_b = 1'b1; addr0_b = 64'h20; wdata0_b = 64'h1234;
      tick();
      check_val("t4_wgnt", {63'd0, gnt0_b}, 64'd1);
      req0_b = 1'b0;
      tick();
      req0_b = 1'b1; wr0_b = 1'b0;
      tick();
      check_val("t4_gnt0", {63'd0, gnt0_b}, 64'd1);
      check_val("t4_busy0", {63'd0, busy_b}, 64'd1);
      req0_b = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            req1_b = 1'b1; wr1_b = 1'b0; addr1_b = 64'h20;
         end
         check_val($sformatf("t4_busy%0d", k), {63'd0, busy_b}, (k <= 5) ? 64'd1 : 64'd0);
         check_val($sformatf("t4_rv0_%0d", k), {63'd0, rvalid0_b}, (k == 5) ? 64'd1 : 64'd0);
         check_val($sformatf("t4_gnt1_%0d", k), {63'd0, gnt1_b}, 64'd0);
         if (k == 5) check_val("t4_rdata0", rdata0_b, 64'h1234);
      end
      tick();
      check_val("t4_gnt1_c7", {63'd0, gnt1_b}, 64'd1);
      req1_b = 1'b0;
      lat = 0; seen = 0;
      for (int k = 1; k <= 10 && seen == 0; k++) begin
         tick();
         if (rvalid1_b) begin
            seen = 1; lat = k; last_rd = rdata1_b;
         end
      end
      check_val("t4_rv1_lat", 64'(lat), 64'd5);
      check_val("t4_rdata1", last_rd, 64'h1234);
      tick();

      // 3: both ports hold read requests right after reset
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      req0_a = 1'b1; wr0_a = 1'b0; addr0_a = 64'h10;
      req1_a = 1'b1; wr1_a = 1'b0; addr1_a = 64'h10;
      ngr = 0; overlap = 0; nrv = 0;
      for (int c = 0; c < 40 && ngr < 4; c++) begin
         tick();
         if (gnt0_a && gnt1_a) overlap++;
         if (gnt0_a || gnt1_a) begin
`ifdef MEM64_ARB_FIXED_PRIO_EN
            exp_port = 64'd0;
`else
            exp_port = 64'(ngr % 2);
`endif
            check_val($sformatf("t3_order%0d", ngr), {63'd0, gnt1_a}, exp_port);
            ngr++;
         end
         if (rvalid0_a || rvalid1_a) begin
            nrv++;
            check_val("t3_rdata", rvalid0_a ? rdata0_a : rdata1_a, 64'hDEADBEEF);
         end
         if (rvalid0_a && rvalid1_a) overlap++;
      end
      check_val("t3_grants", 64'(ngr), 64'd4);
      req0_a = 1'b0; req1_a = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         if (rvalid0_a && rvalid1_a) overlap++;
         if (gnt0_a || gnt1_a) overlap++;
      end
      check_val("t3_overlap", 64'(overlap), 64'd0);

      // 6: port 1 write then read back
      wr_cnt = 0;
      req1_a = 1'b1; wr1_a = 1'b1; addr1_a = 64'h30; wdata1_a = 64'hA5A5_0000_5A5A_1234;
      tick(); wr_cnt += int'(mem_wr_a);
      check_val("t6_wgnt", {63'd0, gnt1_a}, 64'd1);
      wr1_a = 1'b0;
      tick(); wr_cnt += int'(mem_wr_a);
      tick(); wr_cnt += int'(mem_wr_a);
      check_val("t6_rgnt", {63'd0, gnt1_a}, 64'd1);
      req1_a = 1'b0;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         tick(); wr_cnt += int'(mem_wr_a);
         if (rvalid1_a && seen == 0) begin
            seen = 1; last_rd = rdata1_a;
         end
      end
      check_val("t6_seen", 64'(seen), 64'd1);
      check_val("t6_rdata", last_rd, 64'hA5A5_0000_5A5A_1234);
      check_val("t6_wrcnt", 64'(wr_cnt), 64'd1);

      // 5: asynchronous reset during WAIT of a port 0 read on instance b
      req0_b = 1'b1; wr0_b = 1'b0; addr0_b = 64'h20;
      tick();
      check_val("t5_gnt0", {63'd0, gnt0_b}, 64'd1);
      req0_b = 1'b0;
      tick();
      #3 Reset = 1'b1;
      #1;
      check_val("t5_busy", {63'd0, busy_b}, 64'd0);
      check_val("t5_maddr", mem_addr_b, 64'd0);
      check_val("t5_rdata0", rdata0_b, 64'd0);
      check_val("t5_owner", {63'd0, owner_b}, 64'd1);
      check_val("t5_pulses", {61'd0, gnt0_b, rvalid0_b, mem_wr_b}, 64'd0);
      tick();
      Reset = 1'b0;
      nrv = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (rvalid0_b) nrv++;
      end
      check_val("t5_no_rvalid", 64'(nrv), 64'd0);
      req0_b = 1'b1; req1_b = 1'b1; wr1_b = 1'b0;
      tick();
      check_val("t5_tie", {62'd0, gnt0_b, gnt1_b}, 64'd2);
      req0_b = 1'b0; req1_b = 1'b0;
      for (int k = 0; k < 8; k++) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
